// File: rtl/probe_capture_if.sv
`default_nettype none
// probe_capture_if: probe, trigger-setup, status and readout signals of probe_capture.
// Timestamp readout signals exist only when PROBE_CAPTURE_TSTAMP_EN is defined.
interface probe_capture_if #(
    parameter int PROBE_W = 22,
    parameter int ADDR_W  = 8
);
    logic [PROBE_W-1:0] probe_i;
    logic               arm_i;
    logic               disarm_i;
    logic [PROBE_W-1:0] trig_val_i;
    logic [PROBE_W-1:0] trig_mask_i;
    logic               trig_edge_i;
    logic [ADDR_W-1:0]  post_cnt_i;
    logic [ADDR_W-1:0]  rd_addr_i;
    logic [PROBE_W-1:0] rd_data_o;
    logic [1:0]         state_o;
    logic               triggered_o;
    logic               done_o;
    logic [ADDR_W-1:0]  trig_index_o;
`ifdef PROBE_CAPTURE_TSTAMP_EN
    logic [15:0]        rd_ts_o;
    logic [15:0]        trig_ts_o;

    modport master (
        output probe_i, arm_i, disarm_i, trig_val_i, trig_mask_i, trig_edge_i,
               post_cnt_i, rd_addr_i,
        input  rd_data_o, state_o, triggered_o, done_o, trig_index_o, rd_ts_o, trig_ts_o
    );
    modport slave (
        input  probe_i, arm_i, disarm_i, trig_val_i, trig_mask_i, trig_edge_i,
               post_cnt_i, rd_addr_i,
        output rd_data_o, state_o, triggered_o, done_o, trig_index_o, rd_ts_o, trig_ts_o
    );
`else
    modport master (
        output probe_i, arm_i, disarm_i, trig_val_i, trig_mask_i, trig_edge_i,
               post_cnt_i, rd_addr_i,
        input  rd_data_o, state_o, triggered_o, done_o, trig_index_o
    );
    modport slave (
        input  probe_i, arm_i, disarm_i, trig_val_i, trig_mask_i, trig_edge_i,
               post_cnt_i, rd_addr_i,
        output rd_data_o, state_o, triggered_o, done_o, trig_index_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/probe_capture.sv
`default_nettype none
// probe_capture: circular-buffer probe capture with masked level/edge trigger and pre/post split.
// Optional per-sample 16-bit timestamps: define PROBE_CAPTURE_TSTAMP_EN.
module probe_capture #(
    parameter int PROBE_W = 22,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    probe_capture_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  fill_q, fill_d;
    logic [ADDR_W-1:0]  post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]  pre_need_q, pre_need_d;
    logic [ADDR_W-1:0]  remaining_q, remaining_d;
    logic               match_prev_q, match_prev_d;
    logic               triggered_q, triggered_d;
    logic [PROBE_W-1:0] rd_data_q, rd_data_d;
    logic               match, trig_hit, wr_en;
    logic [ADDR_W-1:0]  rd_idx;
    logic [PROBE_W-1:0] mem [DEPTH];

    // arm/disarm pre-empt everything, so a trigger in that cycle is discarded
    always_comb begin
        match    = ((bus.probe_i ^ bus.trig_val_i) & bus.trig_mask_i) == '0;
        trig_hit = (state_q == S_ARMED) && !bus.arm_i && !bus.disarm_i &&
                   (fill_q >= pre_need_q) && match && (!bus.trig_edge_i || !match_prev_q);
        wr_en    = ((state_q == S_ARMED) || (state_q == S_POST)) && !bus.arm_i && !bus.disarm_i;
        rd_idx   = wr_ptr_q + bus.rd_addr_i;
        rd_data_d = mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.arm_i) begin
            state_d = S_ARMED;
        end else if (bus.disarm_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ARMED: if (trig_hit) state_d = (post_cnt_q == '0) ? S_DONE : S_POST;
                S_POST:  if (remaining_q == ADDR_W'(1)) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bus.state_o      = state_q;
        bus.done_o       = (state_q == S_DONE);
        bus.triggered_o  = triggered_q;
        bus.trig_index_o = pre_need_q;
        bus.rd_data_o    = rd_data_q;
    end

    // match_prev forced high on arm so a bus already in match cannot edge-trigger
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        post_cnt_d   = post_cnt_q;
        pre_need_d   = pre_need_q;
        remaining_d  = remaining_q;
        triggered_d  = triggered_q;
        match_prev_d = match;
        if (bus.arm_i) begin
            wr_ptr_d     = '0;
            fill_d       = '0;
            post_cnt_d   = bus.post_cnt_i;
            pre_need_d   = C_LAST - bus.post_cnt_i;
            triggered_d  = 1'b0;
            match_prev_d = 1'b1;
        end else if (bus.disarm_i) begin
            triggered_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (fill_q != C_LAST) fill_d = fill_q + ADDR_W'(1);
            end
            if (trig_hit) begin
                triggered_d = 1'b1;
                remaining_d = post_cnt_q;
            end else if (state_q == S_POST) begin
                remaining_d = remaining_q - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            post_cnt_q   <= '0;
            pre_need_q   <= '0;
            remaining_q  <= '0;
            match_prev_q <= 1'b0;
            triggered_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            post_cnt_q   <= post_cnt_d;
            pre_need_q   <= pre_need_d;
            remaining_q  <= remaining_d;
            match_prev_q <= match_prev_d;
            triggered_q  <= triggered_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // sample memory is deliberately not reset; the read above sees the pre-write value
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.probe_i;
    end

`ifdef PROBE_CAPTURE_TSTAMP_EN
    logic [15:0] ts_cnt_q, ts_cnt_d;
    logic [15:0] trig_ts_q, trig_ts_d;
    logic [15:0] rd_ts_q, rd_ts_d;
    logic [15:0] ts_mem [DEPTH];

    always_comb begin
        if (bus.arm_i)                ts_cnt_d = '0;
        else if (ts_cnt_q == 16'hFFFF) ts_cnt_d = ts_cnt_q;
        else                          ts_cnt_d = ts_cnt_q + 16'd1;
        trig_ts_d     = trig_hit ? ts_cnt_q : trig_ts_q;
        rd_ts_d       = ts_mem[rd_idx];
        bus.rd_ts_o   = rd_ts_q;
        bus.trig_ts_o = trig_ts_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q  <= '0;
            trig_ts_q <= '0;
            rd_ts_q   <= '0;
        end else begin
            ts_cnt_q  <= ts_cnt_d;
            trig_ts_q <= trig_ts_d;
            rd_ts_q   <= rd_ts_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ts_mem[wr_ptr_q] <= ts_cnt_q;
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_probe_capture.sv
`default_nettype none
// tb_probe_capture: directed scoreboard bench for probe_capture (PROBE_W=8, DEPTH=16).
module tb_probe_capture;
    localparam int K_STATE = 0;
    localparam int K_TRIG  = 1;
    localparam int K_DONE  = 2;
    localparam int K_INDEX = 3;
    localparam int K_RDATA = 4;
    localparam int K_TTS   = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic st_issue = 1'b0;
    logic rd_issue = 1'b0;
    logic rd_valid = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t st_q[$];
    exp_t rd_q[$];

    always #5 clk = ~clk;

    probe_capture_if #(.PROBE_W(8), .ADDR_W(4)) bus ();

    probe_capture #(.PROBE_W(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) rd_valid <= rd_issue;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] status_of(input int kind);
        case (kind)
            K_STATE: return 32'(bus.state_o);
            K_TRIG:  return 32'(bus.triggered_o);
            K_DONE:  return 32'(bus.done_o);
            K_INDEX: return 32'(bus.trig_index_o);
            K_RDATA: return 32'(bus.rd_data_o);
`ifdef PROBE_CAPTURE_TSTAMP_EN
            K_TTS:   return 32'(bus.trig_ts_o);
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT presents status or read data
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no read", bus.rd_data_o);
            end else begin
                e = rd_q.pop_front();
`ifdef PROBE_CAPTURE_TSTAMP_EN
                if (e.kind == K_TTS) check(e.name, 32'(bus.rd_ts_o), e.exp);
                else check(e.name, 32'(bus.rd_data_o), e.exp);
`else
                check(e.name, 32'(bus.rd_data_o), e.exp);
`endif
            end
        end
        if (st_issue) begin
            while (st_q.size() > 0) begin
                e = st_q.pop_front();
                check(e.name, status_of(e.kind), e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        st_issue = 1'b0;
        rd_issue = 1'b0;
    endtask

    task automatic expect_st(input string name, input int kind, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.exp = exp;
        st_q.push_back(e);
        st_issue = 1'b1;
    endtask

    task automatic expect_rd(input string name, input logic [3:0] addr, input int kind,
                             input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.exp = exp;
        rd_q.push_back(e);
        bus.rd_addr_i = addr;
        rd_issue = 1'b1;
    endtask

    task automatic arm(input logic [3:0] post, input logic [7:0] val, input logic [7:0] mask,
                       input logic edge_mode, input logic [7:0] p);
        bus.post_cnt_i  = post;
        bus.trig_val_i  = val;
        bus.trig_mask_i = mask;
        bus.trig_edge_i = edge_mode;
        bus.probe_i     = p;
        bus.arm_i       = 1'b1;
        tick();
        bus.arm_i = 1'b0;
    endtask

    task automatic run_basic(input string tag);
        arm(4'd4, 8'h02, 8'h03, 1'b0, 8'h00);
        bus.post_cnt_i = 4'd9;
        expect_st({tag, "_arm_state"}, K_STATE, 1);
        expect_st({tag, "_arm_index"}, K_INDEX, 11);
        for (int p = 0; p <= 18; p++) begin
            bus.probe_i = 8'(p);
            tick();
            if (p == 13) begin
                expect_st({tag, "_pre_state"}, K_STATE, 1);
                expect_st({tag, "_pre_trig"}, K_TRIG, 0);
            end
            if (p == 14) begin
                expect_st({tag, "_hit_state"}, K_STATE, 2);
                expect_st({tag, "_hit_trig"}, K_TRIG, 1);
            end
            if (p == 17) expect_st({tag, "_post_state"}, K_STATE, 2);
        end
        expect_st({tag, "_done_state"}, K_STATE, 3);
        expect_st({tag, "_done"}, K_DONE, 1);
        expect_st({tag, "_index"}, K_INDEX, 11);
        bus.probe_i = 8'hFF;
        for (int a = 0; a < 16; a++) begin
            expect_rd($sformatf("%s_rd%0d", tag, a), 4'(a), K_RDATA, 32'(a + 3));
            tick();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.probe_i = '0; bus.arm_i = 1'b0; bus.disarm_i = 1'b0;
        bus.trig_val_i = '0; bus.trig_mask_i = '0; bus.trig_edge_i = 1'b0;
        bus.post_cnt_i = '0; bus.rd_addr_i = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        expect_st("rst_state", K_STATE, 0);
        expect_st("rst_trig", K_TRIG, 0);
        expect_st("rst_done", K_DONE, 0);
        expect_st("rst_index", K_INDEX, 0);
        expect_st("rst_rdata", K_RDATA, 0);
`ifdef PROBE_CAPTURE_TSTAMP_EN
        expect_st("rst_trig_ts", K_TTS, 0);
`endif
        tick();

        run_basic("lvl");

        // edge mode: bus matching at arm must not trigger until it re-enters
        arm(4'd15, 8'h05, 8'hFF, 1'b1, 8'h05);
        for (int i = 0; i < 3; i++) tick();
        expect_st("edge_hold_state", K_STATE, 1);
        expect_st("edge_hold_trig", K_TRIG, 0);
        bus.probe_i = 8'h00;
        tick();
        expect_st("edge_leave_trig", K_TRIG, 0);
        bus.probe_i = 8'h05;
        tick();
        expect_st("edge_hit_state", K_STATE, 2);
        expect_st("edge_hit_trig", K_TRIG, 1);
        expect_st("edge_index", K_INDEX, 0);
        bus.disarm_i = 1'b1;
        tick();
        bus.disarm_i = 1'b0;
        expect_st("disarm_state", K_STATE, 0);
        expect_st("disarm_trig", K_TRIG, 0);
        tick();

        // post_cnt=15: trigger sample lands at index 0
        arm(4'd15, 8'hA0, 8'hFF, 1'b0, 8'h00);
        bus.probe_i = 8'hA0;
        tick();
        expect_st("p15_hit_trig", K_TRIG, 1);
        expect_st("p15_hit_state", K_STATE, 2);
        for (int p = 8'hA1; p <= 8'hAF; p++) begin
            bus.probe_i = 8'(p);
            tick();
            if (p == 8'hAE) expect_st("p15_post_state", K_STATE, 2);
        end
        expect_st("p15_done", K_DONE, 1);
        expect_rd("p15_rd0", 4'd0, K_RDATA, 32'hA0);
        tick();
        expect_rd("p15_rd7", 4'd7, K_RDATA, 32'hA7);
        tick();
        expect_rd("p15_rd15", 4'd15, K_RDATA, 32'hAF);
        tick();
        tick();

        // post_cnt=0 with all-zero mask: trigger at index 15, straight to DONE
        arm(4'd0, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int p = 0; p <= 15; p++) begin
            bus.probe_i = 8'(p);
            tick();
            if (p == 14) begin
                expect_st("p0_pre_state", K_STATE, 1);
                expect_st("p0_pre_trig", K_TRIG, 0);
            end
        end
        expect_st("p0_done_state", K_STATE, 3);
        expect_st("p0_trig", K_TRIG, 1);
        expect_st("p0_index", K_INDEX, 15);
        expect_rd("p0_rd15", 4'd15, K_RDATA, 32'h0F);
        tick();
        expect_rd("p0_rd0", 4'd0, K_RDATA, 32'h00);
        tick();
        tick();

        // re-arm during POST restarts the pre-trigger fill
        arm(4'd4, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int p = 0; p <= 11; p++) begin
            bus.probe_i = 8'(p);
            tick();
        end
        expect_st("rearm_pre_state", K_STATE, 2);
        arm(4'd4, 8'h00, 8'h00, 1'b0, 8'h20);
        expect_st("rearm_state", K_STATE, 1);
        expect_st("rearm_trig", K_TRIG, 0);
        for (int p = 0; p <= 11; p++) begin
            bus.probe_i = 8'(p);
            tick();
            if (p == 10) expect_st("rearm_fill_trig", K_TRIG, 0);
        end
        expect_st("rearm_hit_trig", K_TRIG, 1);
        expect_st("rearm_hit_state", K_STATE, 2);
        bus.disarm_i = 1'b1;
        arm(4'd4, 8'h00, 8'h00, 1'b0, 8'h00);
        bus.disarm_i = 1'b0;
        expect_st("both_state", K_STATE, 1);
        expect_st("both_trig", K_TRIG, 0);

        // asynchronous reset mid-POST
        for (int p = 0; p <= 12; p++) begin
            bus.probe_i = 8'(p);
            tick();
        end
        expect_st("arst_pre_state", K_STATE, 2);
        tick();
        #1;
        rst_n = 1'b0;
        expect_st("arst_state", K_STATE, 0);
        expect_st("arst_trig", K_TRIG, 0);
        expect_st("arst_index", K_INDEX, 0);
        expect_st("arst_rdata", K_RDATA, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_basic("again");

`ifdef PROBE_CAPTURE_TSTAMP_EN
        arm(4'd4, 8'h28, 8'hFF, 1'b0, 8'h00);
        for (int p = 0; p <= 44; p++) begin
            bus.probe_i = 8'(p);
            tick();
            if (p == 40) expect_st("ts_trig_ts", K_TTS, 40);
        end
        expect_st("ts_done", K_DONE, 1);
        expect_rd("ts_rd_ts", 4'd11, K_TTS, 40);
        tick();
        expect_rd("ts_rd_data", 4'd11, K_RDATA, 32'h28);
        tick();
        tick();
`endif

        tick();
        if (st_q.size() != 0 || rd_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: got %0d pending, expected 0", st_q.size() + rd_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
